// File: rtl/absorb_word_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// absorb_word_sequencer_if : message-in / padding-stage-out bundle  (rev 1.0)
// =============================================================================
interface absorb_word_sequencer_if #(
  parameter int W     = 64,
  parameter int LEN_W = 32
);
  logic             start;
  logic             mode;
  logic [LEN_W-1:0] msg_len_bytes;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [3:0]       remaining_valid_bytes;
  logic             padding_enable;
  logic             last_word_in_block;
  logic             padding_reset;
  logic             block_done;
  logic             msg_done;
  logic             busy;

  // The master side feeds messages and accepts padded words.
  modport master (
    output start, mode, msg_len_bytes, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, remaining_valid_bytes, padding_enable,
           last_word_in_block, padding_reset, block_done, msg_done, busy
  );

  modport slave (
    input  start, mode, msg_len_bytes, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, remaining_valid_bytes, padding_enable,
           last_word_in_block, padding_reset, block_done, msg_done, busy
  );
endinterface
`default_nettype wire

// File: rtl/absorb_word_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// absorb_word_sequencer : forwards message words, then pad words to block end
// Rev 1.0
// =============================================================================
module absorb_word_sequencer #(
  parameter int W              = 64,
  parameter int LEN_W          = 32,
  parameter int RATE_WORDS_128 = 21,
  parameter int RATE_WORDS_256 = 17
) (
  input wire clk,
  input wire rst_n,
  absorb_word_sequencer_if.slave bus
);

  localparam int c_cnt_w = $clog2((RATE_WORDS_128 > RATE_WORDS_256) ? RATE_WORDS_128 : RATE_WORDS_256);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DATA = 2'd2,
    S_PAD  = 2'd3
  } state_t;

  state_t             r_state;
  logic [LEN_W-1:0]   r_bytes_left;
  logic [c_cnt_w-1:0] r_word_cnt;
  logic               r_mode;
  logic               r_padding_reset;
  logic               r_block_done;
  logic               r_msg_done;

  logic [3:0]         w_rem;
  logic [LEN_W-1:0]   w_bytes_next;
  logic [c_cnt_w-1:0] w_last_idx;
  logic               w_at_last;
  logic               w_xfer;

  assign w_rem        = (r_bytes_left >= LEN_W'(8)) ? 4'd8 : r_bytes_left[3:0];
  assign w_bytes_next = r_bytes_left - LEN_W'(w_rem);
  assign w_last_idx   = r_mode ? c_cnt_w'(RATE_WORDS_256 - 1) : c_cnt_w'(RATE_WORDS_128 - 1);
  assign w_at_last    = (r_word_cnt == w_last_idx);
  assign w_xfer       = bus.out_valid && bus.out_ready;

  // Data words pass straight through; pad words are sourced locally as zeros.
  assign bus.out_valid             = (r_state == S_DATA) ? bus.in_valid : (r_state == S_PAD);
  assign bus.in_ready              = (r_state == S_DATA) && bus.out_ready;
  assign bus.out_data              = (r_state == S_DATA) ? bus.in_data : {W{1'b0}};
  assign bus.remaining_valid_bytes = (r_state == S_DATA) ? w_rem : 4'd0;

  // Gated by the transfer so the padding latch only sets on an accepted word.
  assign bus.padding_enable     = (r_bytes_left < LEN_W'(8)) && w_xfer;
  assign bus.last_word_in_block = w_at_last && bus.out_valid;
  assign bus.padding_reset      = r_padding_reset;
  assign bus.block_done         = r_block_done;
  assign bus.msg_done           = r_msg_done;
  assign bus.busy               = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_bytes_left    <= '0;
      r_word_cnt      <= '0;
      r_mode          <= 1'b0;
      r_padding_reset <= 1'b1;
      r_block_done    <= 1'b0;
      r_msg_done      <= 1'b0;
    end else begin
      r_padding_reset <= 1'b0;
      r_block_done    <= 1'b0;
      r_msg_done      <= 1'b0;

      if (w_xfer) begin
        r_word_cnt   <= w_at_last ? '0 : r_word_cnt + c_cnt_w'(1);
        r_block_done <= w_at_last;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mode          <= bus.mode;
            r_bytes_left    <= bus.msg_len_bytes;
            r_word_cnt      <= '0;
            r_padding_reset <= 1'b1;
            r_state         <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_state <= (r_bytes_left != '0) ? S_DATA : S_PAD;
        end
        S_DATA: begin
          if (w_xfer) begin
            r_bytes_left <= w_bytes_next;
            if (w_bytes_next == '0) begin
              r_state <= S_PAD;
            end
          end
        end
        S_PAD: begin
          if (w_xfer && w_at_last) begin
            r_state    <= S_IDLE;
            r_msg_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_absorb_word_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// tb_absorb_word_sequencer : scoreboard bench with a word-list reference model
// Rev 1.0
// =============================================================================
module tb_absorb_word_sequencer;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  rem;
    logic        pe;
    logic        last;
    logic        fin;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  absorb_word_sequencer_if #(.W(64), .LEN_W(32)) bus ();

  absorb_word_sequencer #(
    .W(64), .LEN_W(32), .RATE_WORDS_128(21), .RATE_WORDS_256(17)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  exp_t        exp_q[$];
  logic [63:0] words[$];
  int          exp_blocks;
  int          bd_cnt;
  int          md_cnt;
  int          xfer_cnt;
  logic        pend_done = 1'b0;
  logic        abort = 1'b0;
  int          ready_mode = 0;
  exp_t        mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // out_ready source: 0 = always ready, 1 = random backpressure, 2 = held low
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 0)      bus.out_ready = 1'b1;
      else if (ready_mode == 1) bus.out_ready = ($urandom_range(0, 99) < 70);
      else                      bus.out_ready = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (pend_done || bus.msg_done) chk("msg_done_timing", 64'(bus.msg_done), 64'(pend_done));
      pend_done = 1'b0;
      if (bus.block_done) bd_cnt++;
      if (bus.msg_done)   md_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          fail("unexpected_word");
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_data",  bus.out_data, mon_e.data);
          chk("rem_bytes", 64'(bus.remaining_valid_bytes), 64'(mon_e.rem));
          chk("pad_en",    64'(bus.padding_enable), 64'(mon_e.pe));
          chk("last_word", 64'(bus.last_word_in_block), 64'(mon_e.last));
          pend_done = mon_e.fin;
        end
      end else if (bus.out_valid) begin
        chk("pad_en_stall", 64'(bus.padding_enable), 64'd0);
      end
    end
  end

  // Reference: n data words, then pad words until the block containing the
  // next word slot is closed; an exactly-full block forces a whole pad block.
  task automatic prep_msg(input logic m, input int len);
    int   r, nw, npad, bl;
    exp_t e;
    r  = m ? 17 : 21;
    nw = (len + 7) / 8;
    words.delete();
    for (int i = 0; i < nw; i++) words.push_back({$urandom, $urandom});
    for (int i = 0; i < nw; i++) begin
      bl     = len - 8 * i;
      e.data = words[i];
      e.rem  = (bl >= 8) ? 4'd8 : 4'(bl);
      e.pe   = (bl < 8);
      e.last = ((i % r) == r - 1);
      e.fin  = 1'b0;
      exp_q.push_back(e);
    end
    npad = r - (nw % r);
    for (int j = 0; j < npad; j++) begin
      e.data = 64'd0;
      e.rem  = 4'd0;
      e.pe   = 1'b1;
      e.last = (j == npad - 1);
      e.fin  = (j == npad - 1);
      exp_q.push_back(e);
    end
    exp_blocks = (nw + npad) / r;
    bd_cnt     = 0;
    md_cnt     = 0;
    xfer_cnt   = 0;
  endtask

  task automatic issue_start(input logic m, input int len, input bit glitch);
    @(posedge clk); #1;
    bus.start         = 1'b1;
    bus.mode          = m;
    bus.msg_len_bytes = 32'(len);
    @(posedge clk); #1;
    if (glitch) begin
      bus.mode          = ~m;
      bus.msg_len_bytes = 32'(len + 77);
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      bus.start         = 1'b1;
      bus.msg_len_bytes = 32'd5;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
  endtask

  task automatic drive(input int valid_pct);
    int   idx = 0;
    int   cyc = 0;
    logic fire;
    bus.in_valid = 1'b0;
    while (idx < words.size() && !abort && cyc < 5000) begin
      @(negedge clk);
      fire = bus.in_valid && bus.in_ready && rst_n;
      @(posedge clk); #1;
      cyc++;
      if (fire) begin
        idx++;
        bus.in_valid = 1'b0;
      end
      if (!abort && !bus.in_valid && idx < words.size() && $urandom_range(0, 99) < valid_pct) begin
        bus.in_valid = 1'b1;
        bus.in_data  = words[idx];
      end
    end
    bus.in_valid = 1'b0;
    if (cyc >= 5000) fail("input_drain");
  endtask

  task automatic stall_ctl();
    int stall = 0;
    for (int k = 0; k < 40 && stall < 5; k++) begin
      @(negedge clk);
      if (bus.out_valid && !bus.out_ready) begin
        stall++;
        chk("in_ready_stall", 64'(bus.in_ready), 64'd0);
      end
    end
    if (stall < 5) fail("stall_window");
    @(posedge clk); #1;
    ready_mode = 0;
  endtask

  task automatic finish_msg();
    int k = 0;
    while ((exp_q.size() != 0 || bus.busy) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) fail("msg_timeout");
    repeat (2) @(negedge clk);
    chk("block_done_cnt", 64'(bd_cnt), 64'(exp_blocks));
    chk("msg_done_cnt",   64'(md_cnt), 64'd1);
    chk("busy_idle",      64'(bus.busy), 64'd0);
  endtask

  task automatic run_msg(input logic m, input int len, input int vp, input bit glitch, input bit stall);
    prep_msg(m, len);
    fork
      issue_start(m, len, glitch);
      drive(vp);
      if (stall) stall_ctl();
    join
    finish_msg();
  endtask

  task automatic reset_mid_msg();
    int k;
    ready_mode = 0;
    prep_msg(1'b0, 64);
    fork
      issue_start(1'b0, 64, 1'b0);
      drive(100);
      begin
        k = 0;
        while (xfer_cnt < 3 && k < 100) begin
          @(posedge clk);
          k++;
        end
        if (k >= 100) fail("reset_trigger");
        #2;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_busy",      64'(bus.busy), 64'd0);
        chk("rst_pad_reset", 64'(bus.padding_reset), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready",  64'(bus.in_ready), 64'd0);
        abort = 1'b1;
        rst_n = 1'b1;
        exp_q.delete();
        pend_done = 1'b0;
      end
    join
    abort = 1'b0;
    repeat (3) @(posedge clk);
    chk("rst_no_done", 64'(md_cnt), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic m;
    int   len;
    rst_n             = 1'b0;
    bus.start         = 1'b0;
    bus.mode          = 1'b0;
    bus.msg_len_bytes = '0;
    bus.in_valid      = 1'b0;
    bus.in_data       = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",       64'(bus.busy), 64'd0);
    chk("reset_pad_reset",  64'(bus.padding_reset), 64'd1);
    chk("reset_out_valid",  64'(bus.out_valid), 64'd0);
    chk("reset_in_ready",   64'(bus.in_ready), 64'd0);
    chk("reset_block_done", 64'(bus.block_done), 64'd0);
    chk("reset_msg_done",   64'(bus.msg_done), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_pad_reset", 64'(bus.padding_reset), 64'd0);

    ready_mode = 0;
    run_msg(1'b0, 0,   100, 1'b0, 1'b0);
    run_msg(1'b1, 13,  100, 1'b0, 1'b0);
    run_msg(1'b1, 136, 100, 1'b0, 1'b0);

    ready_mode = 2;
    run_msg(1'b0, 4, 100, 1'b0, 1'b1);

    ready_mode = 1;
    run_msg(1'b0, 50, 60, 1'b1, 1'b0);

    reset_mid_msg();
    ready_mode = 0;
    run_msg(1'b0, 8, 100, 1'b0, 1'b0);

    for (int t = 0; t < 12; t++) begin
      m = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       len = int'($urandom_range(0, 400));
        1:       len = 8 * int'($urandom_range(0, 45));
        default: len = (m ? 136 : 168) * int'($urandom_range(1, 2)) - int'($urandom_range(0, 9));
      endcase
      ready_mode = 1;
      run_msg(m, len, 60, ($urandom_range(0, 3) == 0), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
